axi_mport_rd_ctrl: RTL
======================

AXI_MPORT_RD_CTRL -- requirements
Module: axi_mport_rd_ctrl

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of read requester ports, legal range 1..4.
REQ-002 SHALL have parameter ADDR_W, default 28, AXI address width.
REQ-003 SHALL have parameter DATA_W, default 128, AXI read data width.
REQ-004 SHALL have parameter LEN_W, default 4, burst length field width (beats = len+1).
REQ-005 SHALL have port clk, input, 1, clock; all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid, input, NUM_PORTS, per-port read request pending.
REQ-008 SHALL have port req_addr, input, NUM_PORTS*ADDR_W, per-port start address, port i at bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_len, input, NUM_PORTS*LEN_W, per-port burst length, packed as REQ-008.
REQ-010 SHALL have port req_ready, output, NUM_PORTS, one-cycle grant pulse, request accepted.
REQ-011 SHALL have port rd_data, output, DATA_W, read data, wired straight from axi_rdata.
REQ-012 SHALL have port rd_data_en, output, NUM_PORTS, per-port beat strobe.
REQ-013 SHALL have port rd_done, output, NUM_PORTS, one-cycle burst-complete pulse.
REQ-014 SHALL have port rd_err, output, NUM_PORTS, one-cycle error pulse, coincident with rd_done.
REQ-015 SHALL have AXI AR ports: axi_araddr (out, ADDR_W), axi_arid (out, 4), axi_arlen (out, LEN_W), axi_arsize (out, 3), axi_arburst (out, 2), axi_arvalid (out, 1), axi_arready (in, 1).
REQ-016 SHALL have AXI R ports: axi_rdata (in, DATA_W), axi_rid (in, 4), axi_rresp (in, 2), axi_rvalid (in, 1), axi_rlast (in, 1), axi_rready (out, 1).

Function
REQ-017 SHALL run FSM IDLE -> ADDR -> DATA -> IDLE, with a single outstanding burst.
REQ-018 IDLE: if any req_valid is set, SHALL grant the first set bit searching upward (with wrap) from last_grant+1, pulse req_ready[grant] that cycle, latch addr/len, and enter ADDR next cycle.
REQ-019 SHALL initialise last_grant to NUM_PORTS-1 at reset, so port 0 wins first; last_grant SHALL update on every grant.
REQ-020 ADDR: axi_arvalid=1, araddr/arlen held stable, arid=grant index zero-extended; on arvalid&arready, SHALL deassert arvalid the next cycle and enter DATA.
REQ-021 axi_arsize SHALL be constant log2(DATA_W/8); axi_arburst SHALL be constant 2'b01 (INCR).
REQ-022 axi_rready SHALL be 1 only in DATA.
REQ-023 DATA: each rvalid&rready beat SHALL assert rd_data_en[grant] combinationally and increment a LEN_W+1 bit beat counter cleared on entering DATA.
REQ-024 On the beat with rlast=1, SHALL pulse rd_done[grant] the next cycle and return to IDLE.
REQ-025 rd_err[grant] SHALL pulse with rd_done if, in that burst, any beat had rresp!=0 or rid!=grant, or rlast arrived on a beat count other than len+1.
REQ-026 If the beat count reaches len+1 without rlast, SHALL keep accepting beats until rlast, with error flagged.
REQ-027 rd_data_en SHALL be all-zero outside DATA; R beats outside DATA SHALL be ignored (rready=0).
REQ-028 req_valid changes during ADDR/DATA SHALL have no effect until the next IDLE; a requester SHALL hold req_valid until req_ready.
REQ-029 Minimum turnaround SHALL be 1 IDLE cycle between rd_done and the next arvalid.

Reset
REQ-030 On rst_n low, SHALL go to IDLE immediately with arvalid, rready, req_ready, rd_done, rd_err and rd_data_en at 0, araddr/arlen/arid at 0, and beat counter at 0.
REQ-031 Reset mid-burst SHALL abandon the burst with no rd_done pulse; after release, SHALL behave as from power-up.

Verification
REQ-032 Single port: req_valid[1]=1, addr=0x100, len=7, arready=1, 8 beats with rlast on the 8th -> arid=1, 8 rd_data_en[1] strobes, rd_done[1] once, rd_err=0.
REQ-033 Contention: all ports request simultaneously and continuously -> grants in order 0,1,2,0,1,2; no port starved.
REQ-034 Backpressure: arready low 5 cycles -> arvalid and araddr held stable, exactly one AR handshake.
REQ-035 Error: rresp=2'b10 on beat 3, or rlast on beat 5 with len=7 -> rd_err and rd_done pulse together for the granted port.
REQ-036 Reset asserted in DATA after 3 beats -> outputs zero at once, no rd_done; a new request after release completes normally with port 0 priority.

Source files
------------

// File: rtl/axi_mport_rd_ctrl.sv
// Multi-port AXI read controller: round-robin arbitration between requester
// ports, one outstanding INCR burst at a time, per-port beat/done/error strobes.
module axi_mport_rd_ctrl #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned LEN_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_PORTS-1:0]      req_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*LEN_W-1:0]  req_len,
  output logic [NUM_PORTS-1:0]      req_ready,
  output logic [DATA_W-1:0]         rd_data,
  output logic [NUM_PORTS-1:0]      rd_data_en,
  output logic [NUM_PORTS-1:0]      rd_done,
  output logic [NUM_PORTS-1:0]      rd_err,
  output logic [ADDR_W-1:0]         axi_araddr,
  output logic [3:0]                axi_arid,
  output logic [LEN_W-1:0]          axi_arlen,
  output logic [2:0]                axi_arsize,
  output logic [1:0]                axi_arburst,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  input  logic [DATA_W-1:0]         axi_rdata,
  input  logic [3:0]                axi_rid,
  input  logic [1:0]                axi_rresp,
  input  logic                      axi_rvalid,
  input  logic                      axi_rlast,
  output logic                      axi_rready
);

  localparam int unsigned IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [2:0]  AR_SIZE = 3'($clog2(DATA_W / 8));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W:0]       beat_q, beat_d;
  logic                 err_q, err_d;
  logic [NUM_PORTS-1:0] done_q, done_d;
  logic [NUM_PORTS-1:0] rderr_q, rderr_d;

  logic [IDX_W-1:0]     pick;
  logic                 found;
  logic [NUM_PORTS-1:0] pick_vec;
  logic [NUM_PORTS-1:0] grant_vec;
  logic                 beat;
  logic                 beat_err;

  // Rotating priority: ports above last_grant first, then wrap to the low ports.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!found && req_valid[i] && (i > 32'(last_q))) begin
        pick  = IDX_W'(i);
        found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!found && req_valid[i] && (i <= 32'(last_q))) begin
        pick  = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  assign pick_vec  = found ? (NUM_PORTS'(1) << pick) : '0;
  assign grant_vec = NUM_PORTS'(1) << grant_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    addr_d   = addr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    err_d    = err_q;
    done_d   = '0;
    rderr_d  = '0;
    beat     = 1'b0;
    beat_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          last_d  = pick;
          for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (pick == IDX_W'(i)) begin
              addr_d = req_addr[i*ADDR_W +: ADDR_W];
              len_d  = req_len[i*LEN_W +: LEN_W];
            end
          end
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (axi_arready) begin
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (axi_rvalid) begin
          beat = 1'b1;
          // A full count without rlast is flagged on the beat that reaches len+1.
          beat_err = (axi_rresp != 2'b00) || (axi_rid != 4'(grant_q)) ||
                     (axi_rlast ? (beat_q != {1'b0, len_q}) : (beat_q == {1'b0, len_q}));
          beat_d = beat_q + 1'b1;
          err_d  = err_q | beat_err;
          if (axi_rlast) begin
            done_d  = grant_vec;
            rderr_d = (err_q | beat_err) ? grant_vec : '0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_PORTS - 1);
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= '0;
      rderr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rderr_q <= rderr_d;
    end
  end

  assign req_ready   = (rst_n && (state_q == S_IDLE)) ? pick_vec : '0;
  assign axi_arvalid = (state_q == S_ADDR);
  assign axi_araddr  = addr_q;
  assign axi_arlen   = len_q;
  assign axi_arid    = 4'(grant_q);
  assign axi_arsize  = AR_SIZE;
  assign axi_arburst = 2'b01;
  assign axi_rready  = (state_q == S_DATA);
  assign rd_data     = axi_rdata;
  assign rd_data_en  = beat ? grant_vec : '0;
  assign rd_done     = done_q;
  assign rd_err      = rderr_q;

endmodule
